debug_loader: RTL and testbench
===============================

Name: debug_loader

Overview:
- Front-end control unit that sits directly upstream of top_mips and drives its program-load and enable inputs.
- Receives a byte stream from a UART receiver and assembles 32-bit instructions. Writes the instructions sequentially into instruction memory through top_mips' write port.
- Gates the pipeline enable in continuous or single-step mode.
- Returns the current PC as 4 bytes to a UART transmitter after every run or step.

Parameters:
- NB_DATA, 32, instruction and PC width.
- NB_ADDR, 32, instruction memory address width.
- NB_BYTE, 8, UART byte width.
- ADDR_INC, 1, address increment per written instruction.
- MEM_DEPTH, 64, maximum number of instructions accepted per load.

Ports:
- i_clk  in  1  system clock; all state updates on the rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_rx_valid  in  1  one-cycle pulse; i_rx_data holds a valid byte.
- i_rx_data  in  8  received byte.
- i_halt  in  1  pipeline reached the HALT instruction; level signal.
- i_pc  in  32  current PC from top_mips (o_pc).
- i_tx_ready  in  1  transmitter can accept a byte.
- o_tx_valid  out  1  byte offered to transmitter.
- o_tx_data  out  8  byte to transmit.
- o_write  out  1  instruction-memory write strobe (drives top_mips i_write).
- o_instruction  out  32  word to write (drives top_mips i_instruction).
- o_address  out  32  write address (drives top_mips i_address).
- o_enable  out  1  pipeline enable (drives top_mips i_enable).
- o_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0; the address counter, byte counter, shift register and PC capture register are cleared.
  - A load or send in progress is abandoned, and any partial word is discarded.
- IDLE accepts command bytes on i_rx_valid:
  - 0x4C 'L' → LOAD.
  - 0x43 'C' → RUN.
  - 0x53 'S' → STEP_WAIT.
  - Any other byte is ignored and the state stays IDLE.
- LOAD (word assembly):
  - Each rx byte shifts into the word MSB-first: word = {word[23:0], byte}.
  - The byte counter counts 0..3. The 4th byte moves the FSM to LOAD_WR on the next edge.
- LOAD_WR lasts exactly 1 cycle:
  - o_write=1, o_instruction=word, o_address=addr counter.
  - After the write, addr += ADDR_INC.
  - If word==0 (HALT) or the written count reaches MEM_DEPTH: go to IDLE and clear addr to 0.
  - Otherwise go to LOAD.
  - o_write is 0 in all other states.
  - An rx byte arriving during LOAD_WR is latched as byte 0 of the next word; no byte is lost.
- RUN:
  - o_enable=1 starting from the cycle after the 'C' byte.
  - When i_halt=1 is sampled: o_enable=0 on the following cycle, i_pc is captured, and the FSM goes to SEND. The return state after SEND is IDLE.
  - Rx bytes are ignored in RUN.
- STEP_WAIT:
  - 0x4E 'N' → STEP_PULSE.
  - 0x51 'Q' → IDLE.
  - Other bytes are ignored.
- STEP_PULSE:
  - o_enable=1 for exactly one cycle.
  - On the next cycle i_pc is captured and the FSM goes to SEND.
  - The return state is IDLE if i_halt=1 at capture, otherwise STEP_WAIT.
- SEND:
  - Transmits the captured PC as 4 bytes, MSB first: o_tx_data=pc[31:24], then [23:16], [15:8], [7:0].
  - o_tx_valid stays high with stable data until a cycle where i_tx_ready=1. That cycle completes the transfer.
  - The next byte is presented on the following cycle.
  - After the 4th transfer: o_tx_valid=0 and the FSM moves to the return state.
  - Rx bytes are ignored in SEND.
- o_busy = (state != IDLE), registered.
- The address counter wraps modulo 2^NB_ADDR. MEM_DEPTH normally stops the load first.
- Simultaneous events:
  - A rx byte in the same cycle as a state exit is consumed by the current state only.
  - i_halt arriving while already in SEND has no effect.

Test Plan:
- Reset low mid-LOAD after 2 of 4 bytes, then release and send 'L' plus 4 bytes → o_write pulses at o_address=0 with a freshly assembled word; the old partial bytes do not appear.
- Send 'L', 00 22 30 20, 00 00 00 00 → write pulse with o_instruction=0x00223020 at addr 0, then 0x00000000 at addr 1; FSM returns to IDLE with o_busy=0.
- Load MEM_DEPTH=4 nonzero words (no HALT) → exactly 4 write pulses at addr 0..3, then IDLE; a 5th word's bytes are treated as commands and ignored.
- Send 'C', pipeline raises i_halt with i_pc=0x00000010 → o_enable high until the cycle after halt, then tx bytes 00 00 00 10.
- Send 'C' with i_pc=0x00000010 and i_tx_ready held low 5 cycles per byte → o_tx_valid held and o_tx_data stable throughout; 4 transfers, no duplicate or dropped byte.
- Send 'S', 'N', 'N', 'Q' with i_pc=4 then 8 → each 'N' gives exactly a 1-cycle o_enable; tx 00 00 00 04, then 00 00 00 08; 'Q' returns to IDLE.

Source files
------------

// File: rtl/debug_loader.sv
// UART-driven program loader and run/step controller placed in front of top_mips.
// Assembles MSB-first words into instruction memory, gates the pipeline enable and reports the PC.
module debug_loader #(
   parameter int NB_DATA   = 32,
   parameter int NB_ADDR   = 32,
   parameter int NB_BYTE   = 8,
   parameter int ADDR_INC  = 1,
   parameter int MEM_DEPTH = 64
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_rx_valid,
   input  logic [NB_BYTE-1:0] i_rx_data,
   input  logic               i_halt,
   input  logic [NB_DATA-1:0] i_pc,
   input  logic               i_tx_ready,
   output logic               o_tx_valid,
   output logic [NB_BYTE-1:0] o_tx_data,
   output logic               o_write,
   output logic [NB_DATA-1:0] o_instruction,
   output logic [NB_ADDR-1:0] o_address,
   output logic               o_enable,
   output logic               o_busy
);

   localparam int NBYTES = NB_DATA / NB_BYTE;
   localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int WCW    = $clog2(MEM_DEPTH + 1);
   localparam logic [IDXW-1:0] LAST_B = IDXW'(NBYTES - 1);

   localparam logic [NB_BYTE-1:0] CMD_L = NB_BYTE'(8'h4C);
   localparam logic [NB_BYTE-1:0] CMD_C = NB_BYTE'(8'h43);
   localparam logic [NB_BYTE-1:0] CMD_S = NB_BYTE'(8'h53);
   localparam logic [NB_BYTE-1:0] CMD_N = NB_BYTE'(8'h4E);
   localparam logic [NB_BYTE-1:0] CMD_Q = NB_BYTE'(8'h51);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_LOAD_WR, S_RUN, S_STEP_WAIT, S_STEP_PULSE, S_STEP_CAP, S_SEND
   } state_t;

   state_t             r_state, w_next, r_ret;
   logic [NB_DATA-1:0] r_word, r_pc, w_pc_sh, w_word_sh;
   logic [NB_ADDR-1:0] r_addr;
   logic [IDXW-1:0]    r_cnt, r_bidx;
   logic [WCW-1:0]     r_wcnt;
   logic               r_busy, w_last_wr;

   // A load ends on a HALT (all-zero) word or when the depth budget is used up.
   assign w_last_wr = (r_word == '0) || (r_wcnt == WCW'(MEM_DEPTH - 1));
   assign w_word_sh = {r_word[NB_DATA-NB_BYTE-1:0], i_rx_data};
   assign w_pc_sh   = r_pc << (NB_BYTE * 32'(r_bidx));

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_rx_valid) begin
               if      (i_rx_data == CMD_L) w_next = S_LOAD;
               else if (i_rx_data == CMD_C) w_next = S_RUN;
               else if (i_rx_data == CMD_S) w_next = S_STEP_WAIT;
            end
         end
         S_LOAD:       if (i_rx_valid && r_cnt == LAST_B) w_next = S_LOAD_WR;
         S_LOAD_WR:    w_next = w_last_wr ? S_IDLE : S_LOAD;
         S_RUN:        if (i_halt) w_next = S_SEND;
         S_STEP_WAIT: begin
            if (i_rx_valid) begin
               if      (i_rx_data == CMD_N) w_next = S_STEP_PULSE;
               else if (i_rx_data == CMD_Q) w_next = S_IDLE;
            end
         end
         S_STEP_PULSE: w_next = S_STEP_CAP;
         S_STEP_CAP:   w_next = S_SEND;
         S_SEND:       if (i_tx_ready && r_bidx == LAST_B) w_next = r_ret;
         default:      w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= S_IDLE;
         r_ret   <= S_IDLE;
         r_busy  <= 1'b0;
         r_word  <= '0;
         r_pc    <= '0;
         r_addr  <= '0;
         r_cnt   <= '0;
         r_bidx  <= '0;
         r_wcnt  <= '0;
      end else begin
         r_state <= w_next;
         r_busy  <= (w_next != S_IDLE);
         case (r_state)
            S_IDLE: begin
               if (i_rx_valid && i_rx_data == CMD_L) begin
                  r_cnt  <= '0;
                  r_wcnt <= '0;
               end
            end
            S_LOAD: begin
               if (i_rx_valid) begin
                  r_word <= w_word_sh;
                  r_cnt  <= (r_cnt == LAST_B) ? '0 : r_cnt + 1'b1;
               end
            end
            S_LOAD_WR: begin
               r_addr <= w_last_wr ? '0 : r_addr + NB_ADDR'(ADDR_INC);
               r_wcnt <= r_wcnt + 1'b1;
               // A byte landing during the write cycle starts the next word.
               if (i_rx_valid && !w_last_wr) begin
                  r_word <= w_word_sh;
                  r_cnt  <= IDXW'(1);
               end
            end
            S_RUN: begin
               if (i_halt) begin
                  r_pc   <= i_pc;
                  r_ret  <= S_IDLE;
                  r_bidx <= '0;
               end
            end
            S_STEP_CAP: begin
               r_pc   <= i_pc;
               r_ret  <= i_halt ? S_IDLE : S_STEP_WAIT;
               r_bidx <= '0;
            end
            S_SEND: begin
               if (i_tx_ready) r_bidx <= (r_bidx == LAST_B) ? '0 : r_bidx + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign o_write       = (r_state == S_LOAD_WR);
   assign o_instruction = r_word;
   assign o_address     = r_addr;
   assign o_enable      = (r_state == S_RUN) || (r_state == S_STEP_PULSE);
   assign o_tx_valid    = (r_state == S_SEND);
   assign o_tx_data     = w_pc_sh[NB_DATA-1 -: NB_BYTE];
   assign o_busy        = r_busy;

endmodule

// File: tb/tb_debug_loader.sv
// Randomized scoreboard bench for debug_loader: writes, enable pulse lengths and tx bytes
// are predicted from the command stream and checked by an independent monitor.
module tb_debug_loader;
   localparam int DEPTH = 4;

   logic        clk = 1'b0, rst_n = 1'b0, rx_v = 1'b0, halt = 1'b0, tx_rdy = 1'b0;
   logic [7:0]  rx_d = 8'h0;
   logic [31:0] pc = 32'h0;
   logic        o_tx_valid, o_write, o_enable, o_busy;
   logic [7:0]  o_tx_data;
   logic [31:0] o_instruction, o_address;

   debug_loader #(.MEM_DEPTH(DEPTH)) dut (
      .i_clk(clk), .i_reset(rst_n), .i_rx_valid(rx_v), .i_rx_data(rx_d),
      .i_halt(halt), .i_pc(pc), .i_tx_ready(tx_rdy),
      .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data), .o_write(o_write),
      .o_instruction(o_instruction), .o_address(o_address),
      .o_enable(o_enable), .o_busy(o_busy));

   always #5 clk = ~clk;

   int total = 0, bad = 0;
   logic [63:0] wrq[$];
   logic [7:0]  txq[$];
   int          enq[$];
   logic [31:0] lw[$];
   logic [31:0] sp[$];
   bit          slow = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic fail(input string nm);
      total++;
      bad++;
      $display("FAIL %s", nm);
   endtask

   // monitor: scoreboard pops on each observed DUT event
   int en_len = 0;
   logic pv = 1'b0, pr = 1'b0;
   logic [7:0] pd = 8'h0;
   always @(negedge clk) begin
      if (!rst_n) begin
         en_len = 0;
         pv = 1'b0;
      end else begin
         if (o_write) begin
            if (wrq.size() == 0) fail("unexpected_write");
            else chk("write_addr_instr", {o_address, o_instruction}, wrq.pop_front());
         end
         if (pv && !pr) begin
            chk("tx_valid_hold", 64'(o_tx_valid), 64'd1);
            chk("tx_data_hold", 64'(o_tx_data), 64'(pd));
         end
         if (o_tx_valid && tx_rdy) begin
            if (txq.size() == 0) fail("unexpected_tx");
            else chk("tx_byte", 64'(o_tx_data), 64'(txq.pop_front()));
         end
         pv = o_tx_valid; pr = tx_rdy; pd = o_tx_data;
         if (o_enable) en_len++;
         else if (en_len > 0) begin
            if (enq.size() == 0) fail("unexpected_enable");
            else chk("enable_len", 64'(en_len), 64'(enq.pop_front()));
            en_len = 0;
         end
      end
   end

   int wcnt = 0;
   always @(posedge clk) begin
      #1;
      if (slow) begin
         if (o_tx_valid) begin
            if (wcnt >= 5) begin tx_rdy = 1'b1; wcnt = 0; end
            else begin tx_rdy = 1'b0; wcnt++; end
         end else begin
            tx_rdy = 1'b0; wcnt = 0;
         end
      end else tx_rdy = 1'($urandom_range(0, 1));
   end

   task automatic rx(input logic [7:0] b, input int gap);
      rx_v = 1'b1; rx_d = b;
      @(posedge clk); #1;
      rx_v = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while ((o_busy || txq.size() != 0 || wrq.size() != 0 || enq.size() != 0) && n < 600) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 600) fail({nm, "_timeout"});
      chk({nm, "_busy"}, 64'(o_busy), 64'd0);
   endtask

   task automatic push_pc(input logic [31:0] v);
      for (int k = 3; k >= 0; k--) txq.push_back(v[8*k +: 8]);
   endtask

   // model: word i goes to address i; load stops after a zero word or DEPTH words
   task automatic do_load();
      bit done = 1'b0;
      int i = 0;
      logic [31:0] ws[$];
      while (!done) begin
         logic [31:0] w;
         w = (lw.size() != 0) ? lw.pop_front() : 32'h0;
         ws.push_back(w);
         wrq.push_back({32'(i), w});
         done = (w == 32'h0) || (i + 1 == DEPTH);
         i++;
      end
      lw.delete();
      rx(8'h4C, $urandom_range(0, 2));
      foreach (ws[j]) for (int k = 3; k >= 0; k--) rx(ws[j][8*k +: 8], $urandom_range(0, 2));
      if (ws[ws.size()-1] != 32'h0) for (int k = 0; k < 4; k++) rx(8'h11, 0);
      wait_idle("load");
   endtask

   task automatic rand_load();
      int n = $urandom_range(1, 5);
      for (int j = 0; j < n; j++)
         lw.push_back(($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom | 32'h1));
      do_load();
   endtask

   task automatic run(input logic [31:0] v, input int k);
      int n = 0;
      pc = v;
      push_pc(v);
      enq.push_back(k + 1);
      rx(8'h43, 0);
      @(negedge clk);
      while (!o_enable && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) fail("run_enable_timeout");
      repeat (k) @(negedge clk);
      halt = 1'b1;
      wait_idle("run");
      halt = 1'b0;
   endtask

   task automatic step_seq(input bit last_halt);
      int n;
      rx(8'h53, $urandom_range(0, 2));
      for (int j = 0; sp.size() != 0; j++) begin
         pc = sp.pop_front();
         halt = last_halt && (sp.size() == 0);
         push_pc(pc);
         enq.push_back(1);
         rx(8'h4E, 0);
         n = 0;
         while ((txq.size() != 0 || enq.size() != 0 || o_tx_valid) && n < 300) begin
            @(posedge clk); #1; n++;
         end
         if (n >= 300) fail("step_tx_timeout");
      end
      if (!last_halt) rx(8'h51, 0);
      wait_idle("step");
      halt = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_write", 64'(o_write), 64'd0);
      chk("rst_enable", 64'(o_enable), 64'd0);
      chk("rst_busy", 64'(o_busy), 64'd0);
      chk("rst_txv", 64'(o_tx_valid), 64'd0);
      chk("rst_addr", 64'(o_address), 64'd0);
      chk("rst_instr", 64'(o_instruction), 64'd0);
      chk("rst_txd", 64'(o_tx_data), 64'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // reset in the middle of a word
      rx(8'h4C, 0); rx(8'hAA, 1); rx(8'hBB, 0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_busy", 64'(o_busy), 64'd0);
      chk("midrst_instr", 64'(o_instruction), 64'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      lw = '{32'h12345678, 32'h0};
      do_load();

      lw = '{32'h00223020, 32'h0};
      do_load();
      lw = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
      do_load();

      run(32'h10, 3);
      slow = 1'b1;
      run(32'h10, 1);
      slow = 1'b0;

      sp = '{32'h4, 32'h8};
      step_seq(1'b0);

      for (int it = 0; it < 14; it++) begin
         case ($urandom_range(0, 2))
            0: rand_load();
            1: run($urandom, $urandom_range(0, 5));
            default: begin
               int n = $urandom_range(1, 3);
               for (int j = 0; j < n; j++) sp.push_back($urandom & 32'hFFFFFFFC);
               step_seq(1'($urandom_range(0, 1)));
            end
         endcase
      end
      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
